// File: rtl/seq_ctrl_pkg.sv
// Shared types, defaults and helpers for the serial-pattern detection controller.
package seq_ctrl_pkg;
    localparam int MAXLEN_DEF = 8;
    localparam int CNTW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SCAN
    } state_t;

    function automatic int lenw_of(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

    // A zero length still needs one bit to compare; oversize lengths saturate.
    function automatic int clamp_len(input int len, input int maxlen);
        if (len == 0)
            return 1;
        if (len > maxlen)
            return maxlen;
        return len;
    endfunction
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration handshake, serial stream and status bundle of the detector.
interface seq_detect_ctrl_if
    import seq_ctrl_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
);
    localparam int LENW = lenw_of(MAXLEN);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic [CNTW-1:0]   cfg_limit;
    logic              start;
    logic              abort;
    logic              x;
    logic              x_valid;
    logic              z;
    logic              busy;
    logic              done;
    logic [CNTW-1:0]   match_count;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        output start, abort, x, x_valid,
        input  cfg_ready, z, busy, done, match_count
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        input  start, abort, x, x_valid,
        output cfg_ready, z, busy, done, match_count
    );
endinterface

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked pattern comparator.
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter  int MAXLEN = MAXLEN_DEF,
    localparam int LENW   = lenw_of(MAXLEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              clear,
    input  logic              overlap,
    input  logic              x,
    input  logic [LENW-1:0]   len,
    input  logic [MAXLEN-1:0] pattern,
    output logic              match
);
    logic [MAXLEN-1:0] hist_reg;
    logic [MAXLEN-1:0] hist_next;
    logic [MAXLEN-1:0] mask;
    logic [LENW-1:0]   fill_reg;
    logic [LENW-1:0]   fill_next;

    assign hist_next = {hist_reg[MAXLEN-2:0], x};
    assign fill_next = (fill_reg >= len) ? len : fill_reg + LENW'(1);

    generate
        for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_mask
            assign mask[gi] = (LENW'(gi) < len);
        end
    endgenerate

    assign match = shift && (fill_next == len) && (((hist_next ^ pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (shift) begin
            hist_reg <= hist_next;
            // Without overlap the next match must be built from len fresh bits.
            fill_reg <= (match && !overlap) ? '0 : fill_next;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Runtime-configurable serial-pattern detector with start/abort sequencing and a match limit.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave bus
);
    localparam int LENW = lenw_of(MAXLEN);

    state_t            state_reg;
    logic [MAXLEN-1:0] pat_reg;
    logic [LENW-1:0]   len_reg;
    logic              ovl_reg;
    logic [CNTW-1:0]   lim_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [CNTW-1:0]   cnt_next;
    logic              z_reg;
    logic              done_reg;
    logic              busy_reg;
    logic              ready_reg;
    logic              cfg_fire;
    logic              core_clear;
    logic              core_shift;
    logic              match;

    assign cfg_fire   = bus.cfg_valid && ready_reg;
    assign core_clear = (state_reg == ST_ARMED) && bus.start;
    assign core_shift = (state_reg == ST_SCAN) && bus.x_valid && !bus.abort;
    assign cnt_next   = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNTW'(1);

    seq_match_core #(.MAXLEN(MAXLEN)) u_core (
        .clk     (clk),
        .reset   (reset),
        .shift   (core_shift),
        .clear   (core_clear),
        .overlap (ovl_reg),
        .x       (bus.x),
        .len     (len_reg),
        .pattern (pat_reg),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            pat_reg   <= '0;
            len_reg   <= LENW'(1);
            ovl_reg   <= 1'b0;
            lim_reg   <= '0;
            cnt_reg   <= '0;
            z_reg     <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            z_reg    <= 1'b0;
            done_reg <= 1'b0;
            if (cfg_fire) begin
                pat_reg <= bus.cfg_pattern;
                len_reg <= LENW'(clamp_len(int'(bus.cfg_len), MAXLEN));
                ovl_reg <= bus.cfg_overlap;
                lim_reg <= bus.cfg_limit;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_fire)
                        state_reg <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (bus.start) begin
                        state_reg <= ST_SCAN;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Abort outranks a coincident match.
                    if (bus.abort) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else if (match) begin
                        z_reg   <= 1'b1;
                        cnt_reg <= cnt_next;
                        if ((lim_reg != '0) && (cnt_next == lim_reg)) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            ready_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.z           = z_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = busy_reg;
    assign bus.cfg_ready   = ready_reg;
    assign bus.match_count = cnt_reg;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed table-driven bench for seq_detect_ctrl with hand-written reset sequences.
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.MAXLEN(8), .CNTW(8)) bus ();

    seq_detect_ctrl #(.MAXLEN(8), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        cv;
        logic        st;
        logic        ab;
        logic        xv;
        logic        x;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic        ovl;
        logic [7:0]  lim;
        logic [11:0] exp;   // {z, done, busy, cfg_ready, match_count}
    } vec_t;

    vec_t        tbl[$];
    string       cur_name;
    logic [7:0]  cur_pat;
    logic [3:0]  cur_len;
    logic        cur_ovl;
    logic [7:0]  cur_lim;

    task automatic cfg(input string name, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic [7:0] lim);
        cur_name = name;
        cur_pat  = pat;
        cur_len  = len;
        cur_ovl  = ovl;
        cur_lim  = lim;
    endtask

    task automatic add(input logic cv, input logic st, input logic ab, input logic xv, input logic x,
                       input logic ez, input logic ed, input logic eb, input logic er, input logic [7:0] ec);
        vec_t v;
        v.name = cur_name;
        v.cv = cv; v.st = st; v.ab = ab; v.xv = xv; v.x = x;
        v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl; v.lim = cur_lim;
        v.exp = {ez, ed, eb, er, ec};
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        bus.cfg_valid   = v.cv;
        bus.start       = v.st;
        bus.abort       = v.ab;
        bus.x_valid     = v.xv;
        bus.x           = v.x;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_overlap = v.ovl;
        bus.cfg_limit   = v.lim;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {bus.z, bus.done, bus.busy, bus.cfg_ready, bus.match_count};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got z=%b done=%b busy=%b ready=%b count=%0d, expected z=%b done=%b busy=%b ready=%b count=%0d",
                     name, act[11], act[10], act[9], act[8], act[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end else begin
            $display("[%0t] %s: z=%b done=%b busy=%b ready=%b count=%0d ok",
                     $time, name, act[11], act[10], act[9], act[8], act[7:0]);
        end
    endtask

    task automatic reset_pulse(input string name);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset       = 1'b0;
            bus.cfg_valid = 1'b1;
            bus.start   = 1'b1;
            bus.x_valid = 1'b1;
            bus.x       = 1'b1;
            @(posedge clk);
            #1;
            check(name, {1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
        end
        @(negedge clk);
        reset         = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
        bus.x_valid   = 1'b0;
        bus.x         = 1'b0;
    endtask

    initial begin
        vec_t v;

        // Start ignored in IDLE.
        cfg("idle_start", 8'h00, 4'd1, 1'b0, 8'd0);
        add(0,1,0,0,0, 0,0,0,1,8'd0);

        // Overlap: 1101, stream 1101101.
        cfg("overlap", 8'b1101, 4'd4, 1'b1, 8'd0);
        add(1,0,0,0,0, 0,0,0,1,8'd0);
        add(0,1,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 1,0,1,0,8'd1);
        add(0,0,0,1,1, 0,0,1,0,8'd1);
        add(0,0,0,1,0, 0,0,1,0,8'd1);
        add(0,0,0,1,1, 1,0,1,0,8'd2);
        add(0,0,1,0,0, 0,0,0,1,8'd2);

        // Non-overlap: same stream, one match only.
        cfg("non_overlap", 8'b1101, 4'd4, 1'b0, 8'd0);
        add(1,0,0,0,0, 0,0,0,1,8'd2);
        add(0,1,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 1,0,1,0,8'd1);
        add(0,0,0,1,1, 0,0,1,0,8'd1);
        add(0,0,0,1,0, 0,0,1,0,8'd1);
        add(0,0,0,1,1, 0,0,1,0,8'd1);
        add(0,0,1,0,0, 0,0,0,1,8'd1);

        // Limit: 11, len 2, limit 2; done with the second z, 4th bit ignored.
        cfg("limit", 8'b11, 4'd2, 1'b1, 8'd2);
        add(1,0,0,0,0, 0,0,0,1,8'd1);
        add(0,1,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 1,0,1,0,8'd1);
        add(0,0,0,1,1, 1,1,0,1,8'd2);
        add(0,0,0,1,1, 0,0,0,1,8'd2);

        // Gaps on alternate cycles, then abort as bit 7 completes.
        cfg("gaps_abort", 8'b1101, 4'd4, 1'b1, 8'd0);
        add(1,0,0,0,0, 0,0,0,1,8'd2);
        add(0,1,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,0,1, 0,0,1,0,8'd0);
        add(0,0,0,1,0, 0,0,1,0,8'd0);
        add(0,0,0,0,0, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 1,0,1,0,8'd1);
        add(0,0,0,0,0, 0,0,1,0,8'd1);
        add(0,0,0,1,1, 0,0,1,0,8'd1);
        add(0,0,0,0,0, 0,0,1,0,8'd1);
        add(0,0,0,1,0, 0,0,1,0,8'd1);
        add(0,0,0,0,1, 0,0,1,0,8'd1);
        add(0,0,1,1,1, 0,0,0,1,8'd1);
        add(0,0,0,1,1, 0,0,0,1,8'd1);

        // Overwrite in ARMED with len 0 (clamped to 1), start collides with a valid bit.
        cfg("clamp_start", 8'h00, 4'd1, 1'b1, 8'd0);
        add(1,0,0,0,0, 0,0,0,1,8'd1);
        cfg("clamp_start", 8'b0000_0001, 4'd0, 1'b1, 8'd0);
        add(1,0,0,0,0, 0,0,0,1,8'd1);
        add(0,1,0,1,1, 0,0,1,0,8'd0);
        add(0,0,0,1,1, 1,0,1,0,8'd1);
        add(0,0,0,1,1, 1,0,1,0,8'd2);
        add(0,0,0,1,0, 0,0,1,0,8'd2);
        add(0,0,0,1,1, 1,0,1,0,8'd3);
        add(0,0,0,0,1, 0,0,1,0,8'd3);
        add(0,0,1,0,0, 0,0,0,1,8'd3);

        bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.x_valid = 1'b0; bus.x = 1'b0; bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cfg_limit = '0;

        reset_pulse("reset_init");

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check(tbl[i].name, tbl[i].exp);
        end

        // Mid-scan reset: arm, start, feed two bits, then reset with activity on the inputs.
        cfg("midscan", 8'b1101, 4'd4, 1'b1, 8'd0);
        v.name = "midscan"; v.pat = cur_pat; v.len = cur_len; v.ovl = cur_ovl; v.lim = cur_lim;
        v.ab = 1'b0;
        v.cv = 1'b1; v.st = 1'b0; v.xv = 1'b0; v.x = 1'b0;
        drive(v);
        v.cv = 1'b0; v.st = 1'b1;
        drive(v);
        check("midscan_start", {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        v.st = 1'b0; v.xv = 1'b1; v.x = 1'b1;
        drive(v);
        drive(v);
        check("midscan_busy", {1'b0, 1'b0, 1'b1, 1'b0, 8'd0});
        reset_pulse("reset_midscan");
        v.cv = 1'b0; v.xv = 1'b1; v.x = 1'b1;
        drive(v);
        check("post_reset_idle", {1'b0, 1'b0, 1'b0, 1'b1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller. It accepts a pattern configuration (bit pattern, length, overlap mode, match limit) through a ready/valid handshake. On `start` it scans a qualified serial bit stream, pulses `z` on every match and counts matches. It sits between the control/configuration logic and the serial input path, replacing the hard-wired sequence detector with a runtime-configurable, start/abort-sequenced detector.

## Interface
- `MAXLEN`, 8: maximum pattern length in bits.
- `CNTW`, 8: width of the match counter and the match limit.
- `LENW`, $clog2(MAXLEN)+1: width of `cfg_len`. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  configuration accepted; high in IDLE and ARMED.
- `cfg_pattern`  in  MAXLEN  pattern; `cfg_pattern[len-1]` is the first bit expected, `[0]` is the last.
- `cfg_len`  in  LENW  pattern length; 0 is treated as 1, values above MAXLEN are treated as MAXLEN.
- `cfg_overlap`  in  1  1 = overlapping matches allowed.
- `cfg_limit`  in  CNTW  stop after this many matches; 0 = unlimited.
- `start`  in  1  begin a scan; honoured in ARMED only.
- `abort`  in  1  terminate the scan; honoured in SCAN only.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is sampled only when high.
- `z`  out  1  one-cycle match pulse.
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse when the limit is reached.
- `match_count`  out  CNTW  matches in the current or most recent scan; saturates at all-ones.

## Operation
- States are IDLE, ARMED and SCAN. Reset enters IDLE.
- Configuration:
  - A handshake (`cfg_valid && cfg_ready`) latches the pattern, clamped length, overlap mode and limit.
  - In IDLE the handshake moves the FSM to ARMED.
  - In ARMED the handshake overwrites the configuration and the FSM stays in ARMED.
- `start` in ARMED moves the FSM to SCAN and clears the history, the fill count and `match_count`. `start` in any other state is ignored.
- In SCAN, each cycle with `x_valid` high does the following:
  - Shifts `x` into the history LSB.
  - Increments the fill count, saturating at len.
  - Declares a match when the post-shift fill equals len and the low len bits of the history equal the low len bits of the pattern.
- On a match:
  - `z` pulses and `match_count` increments.
  - With overlap on, the fill count is retained.
  - With overlap off, the fill count is cleared, so a new match needs len fresh bits.
- If `cfg_limit` is nonzero and the incremented count equals `cfg_limit`:
  - `done` pulses together with that final `z`.
  - The FSM returns to IDLE.
  - The configuration is retained. A new scan requires a configuration handshake followed by `start`.
- `abort` in SCAN returns the FSM to IDLE. `match_count` holds its value and `done` does not pulse.
- If `abort` and a match occur in the same cycle, `abort` wins: no `z`, no increment.
- If `start` and `x_valid` are both high in ARMED, that bit is not sampled. Scanning begins on the next cycle.
- `x` is ignored outside SCAN.

## Timing
- Reset values:
  - Outputs: `z`=0, `done`=0, `busy`=0, `match_count`=0, `cfg_ready`=1.
  - Configuration: pattern=0, len=1, overlap=0, limit=0.
- Reset mid-scan: the FSM goes to IDLE on the next edge with all of the above values; nothing partial survives.
- All outputs are registered.
- Latencies:
  - `z` and `done` are high for the single cycle after the edge that sampled the completing bit.
  - `match_count` updates on that same edge.
  - `busy` rises the cycle after `start` is accepted and falls the cycle after `abort` or limit completion.
  - `cfg_ready` falls the cycle after `start` is accepted.
- Throughput is one bit per cycle. Back-to-back matches (overlap, len=1) produce `z` high on consecutive cycles.

## Structure
- Package `seq_ctrl_pkg` holds:
  - the state enum (IDLE/ARMED/SCAN);
  - the MAXLEN default;
  - the LENW derivation;
  - the length-clamp function.
- Sub-module `seq_match_core` holds the history shift register, the fill counter and the masked comparator. Its inputs are shift, clear, overlap, len and pattern; its output is a combinational match.
- The top level holds the FSM, the configuration registers, the counter and the output registers.

## Test plan
- Reset: hold `reset`=0 for 2 cycles mid-activity. Expect `z`=0, `done`=0, `busy`=0, `cfg_ready`=1, `match_count`=0.
- Overlap: pattern 4'b1101, len 4, overlap 1, limit 0; stream 1,1,0,1,1,0,1. Expect `z` after bits 4 and 7, `match_count`=2.
- Non-overlap: same configuration with overlap 0 and the same stream. Expect `z` after bit 4 only, `match_count`=1.
- Limit: pattern 2'b11, len 2, overlap 1, limit 2; stream 1,1,1,1. Expect `z` after bits 2 and 3, `done` with the second `z`, `busy`=0 afterwards, `match_count`=2. The 4th bit is ignored.
- Gaps and abort:
  - Repeat the overlap case with `x_valid` low on alternate cycles. Expect identical matches.
  - Then assert `abort` on the cycle bit 7 completes. Expect no `z`, `match_count`=1, state IDLE.
- Clamp and start collision:
  - `cfg_len`=0 with pattern LSB 1. Expect `z` on every valid 1.
  - Assert `start` together with `x_valid`=1. Expect that bit not counted.
